// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with single-cycle logic/arith ops, Booth multiply and restoring divide
//
// Purpose: executes one operation per accepted start. Logic, add/sub, shift,
// rotate, negate, not and increment finish with latency 1. Signed multiply
// (radix-2 Booth) and signed divide (restoring, on magnitudes) iterate one
// bit per cycle and finish WIDTH+1 cycles after acceptance.
//
// Ports:
//   clk    in   1        system clock, rising edge
//   clr    in   1        synchronous active-high reset
//   start  in   1        operation request, accepted in IDLE or DONE
//   op     in   4        opcode (0 AND .. 12 INCPC, 13-15 illegal)
//   A      in   WIDTH    operand A
//   B      in   WIDTH    operand B (shift/rotate amount in B[SHW-1:0])
//   C      out  2*WIDTH  registered result {HI, LO}
//   busy   out  1        multiply/divide iterating
//   done   out  1        one-cycle pulse, C valid
//   dz     out  1        divide-by-zero, held until next accepted start

module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] C,
  output logic               busy,
  output logic               done,
  output logic               dz
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_MUL   = 4'd4;
  localparam logic [3:0] OP_DIV   = 4'd5;
  localparam logic [3:0] OP_SHR   = 4'd6;
  localparam logic [3:0] OP_SHL   = 4'd7;
  localparam logic [3:0] OP_ROR   = 4'd8;
  localparam logic [3:0] OP_ROL   = 4'd9;
  localparam logic [3:0] OP_NEG   = 4'd10;
  localparam logic [3:0] OP_NOT   = 4'd11;
  localparam logic [3:0] OP_INCPC = 4'd12;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;     // captured A: multiplicand / original dividend
  logic [WIDTH-1:0]   b_q, b_d;     // divisor magnitude (divide only)
  logic [WIDTH:0]     hi_q, hi_d;   // Booth upper accumulator / partial remainder
  logic [WIDTH-1:0]   lo_q, lo_d;   // Booth multiplier bits / dividend-quotient shifter
  logic               qb_q, qb_d;   // Booth q(-1) bit
  logic               qneg_q, qneg_d;
  logic [2*WIDTH-1:0] c_q, c_d;
  logic               dz_q, dz_d;

  // ---------------- single-cycle datapath ----------------
  logic [SHW-1:0]     sh;
  logic [2*WIDTH-1:0] dbl, rot_r, rot_l;
  logic [WIDTH-1:0]   sc_res;

  assign sh    = B[SHW-1:0];
  assign dbl   = {A, A};
  // Rotating the doubled word lets amount 0 fall out naturally with no special case.
  assign rot_r = dbl >> sh;
  assign rot_l = dbl << sh;

  always_comb begin
    sc_res = '0;
    case (op)
      OP_AND:   sc_res = A & B;
      OP_OR:    sc_res = A | B;
      OP_ADD:   sc_res = A + B;
      OP_SUB:   sc_res = A - B;
      OP_SHR:   sc_res = A >> sh;
      OP_SHL:   sc_res = A << sh;
      OP_ROR:   sc_res = rot_r[WIDTH-1:0];
      OP_ROL:   sc_res = rot_l[2*WIDTH-1:WIDTH];
      OP_NEG:   sc_res = '0 - A;
      OP_NOT:   sc_res = ~A;
      OP_INCPC: sc_res = A + WIDTH'(1);
      default:  sc_res = '0;
    endcase
  end

  logic [WIDTH-1:0] abs_a, abs_b;
  assign abs_a = A[WIDTH-1] ? ('0 - A) : A;
  assign abs_b = B[WIDTH-1] ? ('0 - B) : B;

  // ---------------- Booth step ----------------
  // hi carries one guard bit so subtracting the most-negative multiplicand cannot overflow.
  logic [WIDTH:0]   m_ext, booth_sum, booth_hi;
  logic [WIDTH-1:0] booth_lo;

  assign m_ext = {a_q[WIDTH-1], a_q};

  always_comb begin
    booth_sum = hi_q;
    case ({lo_q[0], qb_q})
      2'b10:   booth_sum = hi_q - m_ext;
      2'b01:   booth_sum = hi_q + m_ext;
      default: booth_sum = hi_q;
    endcase
  end

  assign booth_hi = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
  assign booth_lo = {booth_sum[0], lo_q[WIDTH-1:1]};

  // ---------------- restoring divide step ----------------
  logic [WIDTH:0]   r_sh, r_diff, div_r;
  logic [WIDTH-1:0] div_q, q_fix, r_fix;

  assign r_sh   = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
  assign r_diff = r_sh - {1'b0, b_q};

  always_comb begin
    if (!r_diff[WIDTH]) begin
      div_r = r_diff;
      div_q = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      div_r = r_sh;
      div_q = {lo_q[WIDTH-2:0], 1'b0};
    end
  end

  // Quotient sign from operand signs; remainder follows the dividend.
  assign q_fix = qneg_q   ? ('0 - div_q) : div_q;
  assign r_fix = a_q[WIDTH-1] ? ('0 - div_r[WIDTH-1:0]) : div_r[WIDTH-1:0];

  // ---------------- next state ----------------
  logic last_iter;
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    qb_d    = qb_q;
    qneg_d  = qneg_q;
    c_d     = c_q;
    dz_d    = dz_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          a_d    = A;
          cnt_d  = '0;
          dz_d   = 1'b0;
          hi_d   = '0;
          qb_d   = 1'b0;
          qneg_d = 1'b0;
          case (op)
            OP_MUL: begin
              lo_d    = B;
              state_d = S_MUL;
            end
            OP_DIV: begin
              lo_d    = abs_a;
              b_d     = abs_b;
              qneg_d  = A[WIDTH-1] ^ B[WIDTH-1];
              state_d = S_DIV;
            end
            default: begin
              c_d     = {{WIDTH{1'b0}}, sc_res};
              state_d = S_DONE;
            end
          endcase
        end
      end

      S_MUL: begin
        hi_d  = booth_hi;
        lo_d  = booth_lo;
        qb_d  = lo_q[0];
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
          c_d     = {booth_hi[WIDTH-1:0], booth_lo};
          state_d = S_DONE;
        end
      end

      S_DIV: begin
        hi_d  = div_r;
        lo_d  = div_q;
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
          if (b_q == '0) begin
            c_d  = {a_q, {WIDTH{1'b1}}};
            dz_d = 1'b1;
          end else begin
            c_d  = {r_fix, q_fix};
          end
          state_d = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      qb_q    <= 1'b0;
      qneg_q  <= 1'b0;
      c_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      qb_q    <= qb_d;
      qneg_q  <= qneg_d;
      c_q     <= c_d;
      dz_q    <= dz_d;
    end
  end

  assign C    = c_q;
  assign busy = (state_q == S_MUL) || (state_q == S_DIV);
  assign done = (state_q == S_DONE);
  assign dz   = dz_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq (WIDTH=32)

module tb_alu_seq;

  logic        clk;
  logic        clr;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] c;
  logic        busy;
  logic        done;
  logic        dz;

  int n_cmp = 0;
  int n_bad = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .op    (op),
    .A     (a),
    .B     (b),
    .C     (c),
    .busy  (busy),
    .done  (done),
    .dz    (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op from the current sample point; return latency (cycles from
  // the accepting edge to done), busy cycle count and whether C stayed put.
  task automatic run_op(input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb,
                        output int lat, output int bcnt, output bit ok, output bit c_stable);
    logic [63:0] c0;
    op = o; a = va; b = vb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 32'hA5A5_A5A5; b = 32'h5A5A_5A5A; op = 4'hF;
    c0 = c; lat = 1; bcnt = 0; ok = 1'b0; c_stable = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) bcnt++;
      if (c !== c0) c_stable = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    clr = 1'b1; start = 1'b1; op = 4'd2; a = 32'd1; b = 32'd2;
    @(posedge clk); #1;
    n_cmp++; if ({c, busy, done, dz} !== 67'd0) begin n_bad++; $display("FAIL reset_outputs: got c=%h busy=%b done=%b dz=%b, want all 0", c, busy, done, dz); end
    clr = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_start_discarded: got done=%b, want 0", done); end
  endtask

  task automatic test_mul;
    int lat, bc; bit ok, st;
    run_op(4'd4, 32'd22, 32'd24, lat, bc, ok, st);
    n_cmp++; if (!ok || lat != 33) begin n_bad++; $display("FAIL mul_latency: got ok=%0d lat=%0d, want 33", ok, lat); end
    n_cmp++; if (bc != 32) begin n_bad++; $display("FAIL mul_busy_cycles: got %0d, want 32", bc); end
    n_cmp++; if (!st) begin n_bad++; $display("FAIL mul_c_stable: C changed during iterations"); end
    n_cmp++; if (c !== 64'h0000_0000_0000_0210) begin n_bad++; $display("FAIL mul_22x24: got %h, want 0000000000000210", c); end
    run_op(4'd4, 32'hFFFF_FFFD, 32'd5, lat, bc, ok, st);
    n_cmp++; if (c !== 64'hFFFF_FFFF_FFFF_FFF1) begin n_bad++; $display("FAIL mul_neg3x5: got %h, want FFFFFFFFFFFFFFF1", c); end
    run_op(4'd4, 32'h8000_0000, 32'h8000_0000, lat, bc, ok, st);
    n_cmp++; if (c !== 64'h4000_0000_0000_0000) begin n_bad++; $display("FAIL mul_minneg_sq: got %h, want 4000000000000000", c); end
  endtask

  task automatic test_div;
    int lat, bc; bit ok, st;
    run_op(4'd5, 32'hFFFF_FFF9, 32'd2, lat, bc, ok, st);
    n_cmp++; if (!ok || lat != 33) begin n_bad++; $display("FAIL div_latency: got ok=%0d lat=%0d, want 33", ok, lat); end
    n_cmp++; if (c !== 64'hFFFF_FFFF_FFFF_FFFD || dz !== 1'b0) begin n_bad++; $display("FAIL div_neg7_2: got c=%h dz=%b, want FFFFFFFFFFFFFFFD dz=0", c, dz); end
    run_op(4'd5, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, ok, st);
    n_cmp++; if (c !== 64'h0000_0000_8000_0000 || dz !== 1'b0) begin n_bad++; $display("FAIL div_minneg_m1: got c=%h dz=%b, want 0000000080000000 dz=0", c, dz); end
  endtask

  task automatic test_div_zero;
    int lat, bc; bit ok, st;
    run_op(4'd5, 32'd9, 32'd0, lat, bc, ok, st);
    n_cmp++; if (!ok || lat != 33) begin n_bad++; $display("FAIL divz_latency: got ok=%0d lat=%0d, want 33", ok, lat); end
    n_cmp++; if (c !== 64'h0000_0009_FFFF_FFFF || dz !== 1'b1) begin n_bad++; $display("FAIL divz_result: got c=%h dz=%b, want 00000009FFFFFFFF dz=1", c, dz); end
    @(posedge clk); #1;
    n_cmp++; if (dz !== 1'b1) begin n_bad++; $display("FAIL divz_dz_held: got dz=%b, want 1", dz); end
    run_op(4'd2, 32'd22, 32'd24, lat, bc, ok, st);
    n_cmp++; if (!ok || lat != 1 || c !== 64'h2E || dz !== 1'b0) begin n_bad++; $display("FAIL divz_then_add: got lat=%0d c=%h dz=%b, want lat=1 c=2e dz=0", lat, c, dz); end
  endtask

  task automatic test_single;
    logic [3:0]  ops [12];
    logic [31:0] va  [12];
    logic [31:0] vb  [12];
    logic [63:0] exp [12];
    int lat, bc; bit ok, st;
    ops[0]  = 4'd0;  va[0]  = 32'hF0F0_F0F0; vb[0]  = 32'hFF00_FF00; exp[0]  = 64'hF000_F000;
    ops[1]  = 4'd1;  va[1]  = 32'hF0F0_F0F0; vb[1]  = 32'hFF00_FF00; exp[1]  = 64'hFFF0_FFF0;
    ops[2]  = 4'd3;  va[2]  = 32'd5;         vb[2]  = 32'd7;         exp[2]  = 64'hFFFF_FFFE;
    ops[3]  = 4'd6;  va[3]  = 32'h8000_0000; vb[3]  = 32'd4;         exp[3]  = 64'h0800_0000;
    ops[4]  = 4'd7;  va[4]  = 32'h0000_0001; vb[4]  = 32'd31;        exp[4]  = 64'h8000_0000;
    ops[5]  = 4'd8;  va[5]  = 32'h0000_0001; vb[5]  = 32'd1;         exp[5]  = 64'h8000_0000;
    ops[6]  = 4'd9;  va[6]  = 32'h8000_0000; vb[6]  = 32'd33;        exp[6]  = 64'h0000_0001;
    ops[7]  = 4'd8;  va[7]  = 32'h1234_5678; vb[7]  = 32'd32;        exp[7]  = 64'h1234_5678;
    ops[8]  = 4'd10; va[8]  = 32'd1;         vb[8]  = 32'd0;         exp[8]  = 64'hFFFF_FFFF;
    ops[9]  = 4'd11; va[9]  = 32'h0F0F_0F0F; vb[9]  = 32'd0;         exp[9]  = 64'hF0F0_F0F0;
    ops[10] = 4'd12; va[10] = 32'hFFFF_FFFF; vb[10] = 32'd0;         exp[10] = 64'h0;
    ops[11] = 4'd13; va[11] = 32'h1234_5678; vb[11] = 32'h1;         exp[11] = 64'h0;
    for (int i = 0; i < 12; i++) begin
      run_op(ops[i], va[i], vb[i], lat, bc, ok, st);
      n_cmp++;
      if (!ok || lat != 1 || c !== exp[i] || dz !== 1'b0) begin
        n_bad++;
        $display("FAIL single_op%0d: got lat=%0d c=%h dz=%b, want lat=1 c=%h dz=0", ops[i], lat, c, dz, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_clr_abort;
    int lat, bc; bit ok, st;
    bit seen;
    op = 4'd4; a = 32'd22; b = 32'd24; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 9; k++) begin @(posedge clk); #1; end
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    n_cmp++; if (c !== 64'h0 || busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL clr_abort_state: got c=%h busy=%b done=%b, want 0/0/0", c, busy, done); end
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_cmp++; if (seen) begin n_bad++; $display("FAIL clr_abort_no_done: got done pulse, want none"); end
    run_op(4'd2, 32'd1, 32'd2, lat, bc, ok, st);
    n_cmp++; if (!ok || lat != 1 || c !== 64'd3) begin n_bad++; $display("FAIL clr_then_add: got lat=%0d c=%h, want lat=1 c=3", lat, c); end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start;
    int lat;
    bit ok;
    op = 4'd5; a = 32'd100; b = 32'hFFFF_FFF9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 32'd0; b = 32'd0;
    lat = 1; ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (done) begin ok = 1'b1; break; end
      if (lat == 5) begin start = 1'b1; op = 4'd2; a = 32'd1; b = 32'd1; end
      else start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    n_cmp++; if (!ok || lat != 33) begin n_bad++; $display("FAIL ignore_latency: got ok=%0d lat=%0d, want 33", ok, lat); end
    n_cmp++; if (c !== 64'h0000_0002_FFFF_FFF2) begin n_bad++; $display("FAIL ignore_result: got %h, want 00000002FFFFFFF2", c); end
  endtask

  task automatic test_back_to_back;
    int lat, bc; bit ok, st;
    run_op(4'd4, 32'd3, 32'd4, lat, bc, ok, st);
    run_op(4'd5, 32'hFFFF_FF9C, 32'd7, lat, bc, ok, st);
    n_cmp++; if (!ok || lat != 33 || bc != 32) begin n_bad++; $display("FAIL b2b_div_timing: got ok=%0d lat=%0d busy=%0d, want 33/32", ok, lat, bc); end
    n_cmp++; if (c !== 64'hFFFF_FFFE_FFFF_FFF2) begin n_bad++; $display("FAIL b2b_div_result: got %h, want FFFFFFFEFFFFFFF2", c); end
    run_op(4'd2, 32'hFFFF_FFFF, 32'd2, lat, bc, ok, st);
    n_cmp++; if (!ok || lat != 1 || c !== 64'h1) begin n_bad++; $display("FAIL b2b_add: got lat=%0d c=%h, want lat=1 c=1", lat, c); end
    @(posedge clk); #1;
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; op = 4'd0; a = '0; b = '0;
    @(posedge clk); @(posedge clk); #1;
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_single();
    test_clr_abort();
    test_ignore_start();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
